bcd_display_scan: RTL and testbench
===================================

Name: bcd_display_scan

Overview:
Drives a 4-digit common-anode multiplexed 7-segment display from four BCD digits, such as the four-digit BCD counter output. It time-multiplexes one digit at a time at a programmable refresh rate and decodes BCD to active-low segments. It also snapshots all four digits at each frame boundary so a displayed frame never mixes old and new counter values.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz / 100000 = 1 kHz slot, 250 Hz frame); legal range ≥ 2
CNT_W, 17, width of the refresh counter; must satisfy 2^CNT_W ≥ REFRESH_DIV

Ports:
clock  in  1  system clock; single clock domain
rst    in  1  synchronous, active-high reset
digit0 in  4  BCD least significant digit
digit1 in  4  BCD digit
digit2 in  4  BCD digit
digit3 in  4  BCD most significant digit
dp_in  in  4  decimal point request per digit, bit i = digit i, active-high
seg    out 7  {g,f,e,d,c,b,a}, active-low, registered
dp     out 1  decimal point, active-low, registered
an     out 4  anode select, active-low one-hot, registered, bit i = digit i

Behaviour:
- Reset is synchronous (rst sampled at posedge clock) and overrides everything. It sets:
  - cnt=0, idx=0, snapshot digits=0, snapshot dp=0
  - an=4'b1111, seg=7'b1111111, dp=1
- Refresh counter:
  - cnt counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = (cnt == REFRESH_DIV-1).
- Scan index:
  - On each tick edge, idx advances 0→1→2→3→0.
  - idx holds between ticks.
- Snapshot:
  - On the tick edge where idx==3 (frame boundary, idx→0), the snapshot registers capture digit0..3 and dp_in.
  - Between frame boundaries, input changes have no effect on the display.
  - The first frame after reset displays 0000.
- Output stage:
  - an, seg and dp are registered from the current idx and snapshot.
  - They reflect a new idx exactly 1 cycle after the idx change.
  - an = ~(4'b0001 << idx); exactly one bit is low at all times after the first post-reset cycle.
  - dp = ~snap_dp[idx].
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Non-BCD digit values (10–15) decode to a dash: 0111111 (segment g only).
- No glitching: an and seg change on the same edge.
- Reset asserted mid-frame: outputs blank on the next edge. Scanning restarts at idx=0 with a fresh count of REFRESH_DIV cycles.

Optional Feature:
Macro: BCD_DISPLAY_SCAN_LZB_EN (leading-zero blanking)
- Defined:
  - digit3 is blanked if snap3==0.
  - digit2 is blanked if snap3==0 and snap2==0.
  - digit1 is blanked if snap3, snap2 and snap1 are all 0.
  - digit0 is never blanked.
  - Blanked slot: seg=1111111, an still asserted, dp still honoured.
- Undefined: all digits are always decoded; 0007 shows as "0007".

Decomposition:
- Package seg7_pkg holds:
  - SEG_W=7
  - the ten digit segment constants SEG_0..SEG_9
  - SEG_BLANK=7'b1111111
  - SEG_DASH=7'b0111111
  - AN_OFF=4'b1111
- Sub-module bcd_to_seg7: purely combinational 4-bit BCD → 7-bit active-low segments, with dash for values 10–15. It is instantiated once, muxed by idx.

Test Plan (REFRESH_DIV=4):
1. Reset/scan: rst high 3 cycles → an=1111, seg=1111111, dp=1. Release with digits=1,2,3,4. During the first frame, an steps 1110→1101→1011→0111, each held 4 cycles, seg=1000000 throughout (snapshot is 0). In the second frame, an=1110 shows seg=1111001 ("1") and an=0111 shows seg=0011001 ("4").
2. Snapshot coherence: change digits from 1234 to 5678 while idx=1 → the remaining slots of that frame still show 2,3,4. "8" (0000000) first appears on an=1110 in the next frame.
3. Decimal point and illegal value: dp_in=0100, digit2=4'hB → in the slot with an=1011, dp=0 and seg=0111111. In other slots, dp=1.
4. Reset mid-scan: assert rst while idx=2 → the next edge gives an=1111, seg=1111111. After release, the first an=1110 appears 1 cycle after release, and the next change to an=1101 comes 4 cycles later.
5. Leading-zero blanking (LZB_EN defined): digits=0,0,0,7 (digit3..0) → slots for digit3..1 show seg=1111111 with an active; digit0 shows 1111000. Digits=0,0,0,0 → only digit0 shows 1000000. Without the macro, 0007 shows all four digits.
6. Long-run wrap: run 1000 cycles → an is always one-hot-low, never 1111. The slot period is exactly REFRESH_DIV cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for active-low 7-segment displays.
// Segment vectors are ordered {g,f,e,d,c,b,a}. Anode vectors are active-low.
package seg7_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Values 10-15 are shown as a dash so that a bad digit is visible on the display.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0]       bcd,
  output logic [SEG_W-1:0] seg
);

  // NOTE: seg gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scan.sv
// Scans four BCD digits onto a multiplexed common-anode 7-segment display.
// Define BCD_DISPLAY_SCAN_LZB_EN to blank leading zeros in digits 3..1.
module bcd_display_scan
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [3:0]       digit0,
  input  logic [3:0]       digit1,
  input  logic [3:0]       digit2,
  input  logic [3:0]       digit3,
  input  logic [3:0]       dp_in,
  output logic [SEG_W-1:0] seg,
  output logic             dp,
  output logic [3:0]       an
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [1:0]       idx;
  logic [3:0][3:0]  snap;
  logic [3:0]       snap_dp;
  logic [SEG_W-1:0] dec_seg;
  logic             blank;

  assign tick = (cnt == CNT_MAX);

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (tick) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // NOTE: the snapshot is reset, unlike a plain data store, because the first
  // frame after reset must show a defined 0000 rather than whatever powered up.
  always_ff @(posedge clock) begin
    if (rst) begin
      snap    <= '0;
      snap_dp <= '0;
    end else if (tick && idx == 2'd3) begin
      snap    <= {digit3, digit2, digit1, digit0};
      snap_dp <= dp_in;
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (snap[idx]),
    .seg (dec_seg)
  );

  always_comb begin
    blank = 1'b0;
`ifdef BCD_DISPLAY_SCAN_LZB_EN
    case (idx)
      2'd3:    blank = (snap[3] == 4'd0);
      2'd2:    blank = (snap[3] == 4'd0) && (snap[2] == 4'd0);
      2'd1:    blank = (snap[3] == 4'd0) && (snap[2] == 4'd0) && (snap[1] == 4'd0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
  end

  // an, seg and dp share one register stage so they switch on the same edge.
  always_ff @(posedge clock) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= blank ? SEG_BLANK : dec_seg;
      dp  <= ~snap_dp[idx];
    end
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan with REFRESH_DIV=4.
// Expected frames are queued when digits are driven and popped as frames are displayed.
module tb_bcd_display_scan;

  localparam int REFRESH_DIV = 4;
  localparam int CNT_W       = 2;
  localparam int NV          = 8;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic [3:0] digit0 = '0, digit1 = '0, digit2 = '0, digit3 = '0;
  logic [3:0] dp_in = '0;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  always #5 clock = ~clock;

  bcd_display_scan #(.REFRESH_DIV(REFRESH_DIV), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .rst    (rst),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .dp_in  (dp_in),
    .seg    (seg),
    .dp     (dp),
    .an     (an)
  );

  typedef struct {
    logic [15:0]     digits;   // {digit3,digit2,digit1,digit0}
    logic [3:0]      dp_req;
    int              slot;     // slot of the displayed frame in which to drive it
    logic [3:0][6:0] exp_seg;  // per slot, slot 3 first
    logic [3:0]      exp_dp;   // active-low per slot
  } vec_t;

  typedef struct packed {
    logic [3:0][6:0] seg;
    logic [3:0]      dp;
  } frame_t;

  vec_t   vecs [NV];
  frame_t exp_q[$];
  int     n_cmp    = 0;
  int     n_bad    = 0;
  int     frame_no = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int vi);
    frame_t f;
    {digit3, digit2, digit1, digit0} = vecs[vi].digits;
    dp_in = vecs[vi].dp_req;
    f.seg = vecs[vi].exp_seg;
    f.dp  = vecs[vi].exp_dp;
    exp_q.push_back(f);
  endtask

  // Checks one 16-cycle frame against the oldest queued expectation; optionally
  // drives vector vi at the start of its chosen slot.
  task automatic run_frame(input int vi);
    frame_t     f;
    logic [3:0] exp_an;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard f%0d: got empty queue expected a frame", frame_no);
      f = '0;
    end else begin
      f = exp_q.pop_front();
    end
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < REFRESH_DIV; c++) begin
        if (vi >= 0 && s == vecs[vi].slot && c == 0) drive(vi);
        step();
        exp_an = ~(4'b0001 << s);
        check($sformatf("an f%0d s%0d c%0d", frame_no, s, c), an, exp_an);
        check($sformatf("seg f%0d s%0d c%0d", frame_no, s, c), seg, f.seg[s]);
        check($sformatf("dp f%0d s%0d c%0d", frame_no, s, c), dp, f.dp[s]);
      end
    end
    frame_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    frame_t     f0;
    logic [3:0] prev_an;
    logic [3:0] exp_an;
    int         run_len;

    vecs[0] = '{16'h4321, 4'b0000, 0,
                {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}, 4'b1111};
    vecs[1] = '{16'h5678, 4'b0000, 1,
                {7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000}, 4'b1111};
    vecs[2] = '{16'h9B01, 4'b0100, 0,
                {7'b0010000, 7'b0111111, 7'b1000000, 7'b1111001}, 4'b1011};
    vecs[6] = '{16'hFEDC, 4'b1111, 0,
                {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}, 4'b0000};
    vecs[7] = '{16'h1000, 4'b0001, 0,
                {7'b1111001, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1110};
`ifdef BCD_DISPLAY_SCAN_LZB_EN
    vecs[3] = '{16'h0007, 4'b0000, 0,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111000}, 4'b1111};
    vecs[4] = '{16'h0000, 4'b1000, 0,
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}, 4'b0111};
    vecs[5] = '{16'h0500, 4'b0000, 0,
                {7'b1111111, 7'b0010010, 7'b1000000, 7'b1000000}, 4'b1111};
    f0.seg  = {7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000};
`else
    vecs[3] = '{16'h0007, 4'b0000, 0,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1111000}, 4'b1111};
    vecs[4] = '{16'h0000, 4'b1000, 0,
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b0111};
    vecs[5] = '{16'h0500, 4'b0000, 0,
                {7'b1000000, 7'b0010010, 7'b1000000, 7'b1000000}, 4'b1111};
    f0.seg  = {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
`endif
    f0.dp = 4'b1111;

    // Reset held for three cycles: display dark.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("reset an c%0d", i), an, 4'b1111);
      check($sformatf("reset seg c%0d", i), seg, 7'b1111111);
      check($sformatf("reset dp c%0d", i), dp, 1'b1);
    end

    // First frame shows the reset snapshot; 1234 is captured at its end.
    exp_q.push_back(f0);
    drive(0);
    rst = 1'b0;
    run_frame(-1);
    for (int i = 1; i < NV; i++) run_frame(i);
    run_frame(-1);

    // Reset while idx==2: blank on the next edge, then a full fresh slot 0.
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    check("midrst an", an, 4'b1111);
    check("midrst seg", seg, 7'b1111111);
    check("midrst dp", dp, 1'b1);
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("postrst an c%0d", i), an, 4'b1110);
      if (i == 1) check("postrst seg", seg, 7'b1000000);
    end
    step();
    check("postrst an c5", an, 4'b1101);

    // Long run: one-hot-low anodes rotating every REFRESH_DIV cycles.
    prev_an = an;
    run_len = 1;
    for (int i = 0; i < 1000; i++) begin
      step();
      check($sformatf("onehot c%0d", i), $countones(~an), 1);
      if (an !== prev_an) begin
        exp_an = {prev_an[2:0], prev_an[3]};
        check($sformatf("rotate c%0d", i), an, exp_an);
        check($sformatf("period c%0d", i), run_len, REFRESH_DIV);
        prev_an = an;
        run_len = 1;
      end else begin
        run_len++;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
